vanilla_pc_hist_counter_ctrl: RTL and testbench

//  Hardware PC-histogram counter table shared by num_src_p event sources (instr/stall classifiers of a tile).

---
 rtl/vanilla_pc_hist_counter_ctrl.sv | 146 ++++++++++++++
 tb/tb_vanilla_pc_hist_counter_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vanilla_pc_hist_counter_ctrl.sv
// vanilla_pc_hist_counter_ctrl: round-robin arbitrated saturating PC-histogram counter table with clear sweep and dump port
module vanilla_pc_hist_counter_ctrl #(
  parameter int num_src_p   = 4,
  parameter int els_p       = 256,
  parameter int ctr_width_p = 32,
  parameter int lg_els_lp   = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           clear_i,
  input  logic                           dump_i,
  input  logic [num_src_p-1:0]           req_v_i,
  input  logic [num_src_p*lg_els_lp-1:0] req_addr_i,
  output logic [num_src_p-1:0]           req_yumi_o,
  output logic                           dump_v_o,
  output logic [lg_els_lp-1:0]           dump_addr_o,
  output logic [ctr_width_p-1:0]         dump_data_o,
  input  logic                           dump_ready_i,
  output logic                           busy_o,
  output logic                           overflow_o
);
  localparam int lg_src_lp = (num_src_p > 1) ? $clog2(num_src_p) : 1;
  typedef enum logic [1:0] {e_clear, e_run, e_drain, e_dump} state_e;
  state_e state_q, state_d;
  logic [ctr_width_p-1:0] mem_r [els_p];
  logic [ctr_width_p-1:0] rdata_q, byp_data_q, byp_data_d, old, incr, wd;
  logic [ctr_width_p-1:0] dump_data_q, dump_data_d;
  logic [lg_els_lp-1:0] clr_addr_q, clr_addr_d, s1_addr_q, s1_addr_d, byp_addr_q, byp_addr_d;
  logic [lg_els_lp-1:0] fetch_addr_q, fetch_addr_d, dump_addr_q, dump_addr_d, gnt_addr, wa, ra;
  logic [lg_els_lp:0] rd_idx_q, rd_idx_d;
  logic [lg_src_lp-1:0] last_q, last_d, gnt_idx, cand;
  logic [num_src_p-1:0] yumi;
  logic to_dump_q, to_dump_d, s1_v_q, s1_v_d, byp_v_q, byp_v_d, fetched_q, fetched_d;
  logic dump_v_q, dump_v_d, overflow_q, overflow_d, busy_q, busy_d;
  logic gnt_v, sat, we, re, in_dump, load, issue, dump_done;
  always_comb begin
    yumi = '0;
    gnt_idx = last_q;
    gnt_v = 1'b0;
    cand = '0;
    for (int i = 1; i <= num_src_p; i++) begin
      cand = lg_src_lp'((int'(last_q) + i) % num_src_p);
      if (!gnt_v && req_v_i[cand] && state_q == e_run && !clear_i && !dump_i) begin
        gnt_v = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_v) yumi[gnt_idx] = 1'b1;
  end
  assign gnt_addr = req_addr_i[gnt_idx*lg_els_lp +: lg_els_lp];
  assign old = (byp_v_q && byp_addr_q == s1_addr_q) ? byp_data_q : rdata_q;
  assign sat = &old;
  assign incr = sat ? old : old + 1'b1;
  assign we = (state_q == e_clear) || s1_v_q;
  assign wa = (state_q == e_clear) ? clr_addr_q : s1_addr_q;
  assign wd = (state_q == e_clear) ? '0 : incr;
  assign in_dump = (state_q == e_dump);
  assign load = in_dump && fetched_q && (!dump_v_q || dump_ready_i);
  assign issue = in_dump && !clear_i && rd_idx_q != (lg_els_lp+1)'(els_p) && (!fetched_q || load);
  assign dump_done = in_dump && dump_v_q && dump_ready_i && dump_addr_q == lg_els_lp'(els_p - 1);
  assign re = gnt_v || issue;
  assign ra = gnt_v ? gnt_addr : rd_idx_q[lg_els_lp-1:0];
  always_comb begin
    state_d = state_q;
    clr_addr_d = '0;
    to_dump_d = to_dump_q;
    case (state_q)
      e_clear: begin
        clr_addr_d = clear_i ? '0 : clr_addr_q + 1'b1;
        if (!clear_i && clr_addr_q == lg_els_lp'(els_p - 1)) state_d = e_run;
      end
      e_run: begin
        to_dump_d = !clear_i;
        if (clear_i || dump_i) state_d = e_drain;
      end
      e_drain: begin
        to_dump_d = to_dump_q && !clear_i;
        if (!s1_v_q) state_d = to_dump_d ? e_dump : e_clear;
      end
      default: state_d = clear_i ? e_clear : dump_done ? e_run : e_dump;
    endcase
  end
  assign last_d = gnt_v ? gnt_idx : last_q;
  assign s1_v_d = gnt_v;
  assign s1_addr_d = gnt_v ? gnt_addr : s1_addr_q;
  assign byp_v_d = we;
  assign byp_addr_d = wa;
  assign byp_data_d = wd;
  assign overflow_d = (state_q == e_clear) ? 1'b0 : overflow_q || (s1_v_q && sat);
  assign rd_idx_d = !in_dump ? '0 : issue ? rd_idx_q + 1'b1 : rd_idx_q;
  assign fetched_d = !in_dump ? 1'b0 : issue ? 1'b1 : load ? 1'b0 : fetched_q;
  assign fetch_addr_d = issue ? rd_idx_q[lg_els_lp-1:0] : fetch_addr_q;
  assign dump_v_d = (!in_dump || clear_i) ? 1'b0 : load ? 1'b1 : dump_ready_i ? 1'b0 : dump_v_q;
  assign dump_addr_d = load ? fetch_addr_q : dump_addr_q;
  assign dump_data_d = load ? rdata_q : dump_data_q;
  assign busy_d = (state_d != e_run);
  always_ff @(posedge clk_i) begin
    if (we) mem_r[wa] <= wd;
    if (re) rdata_q <= mem_r[ra];
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_clear;
      clr_addr_q <= '0;
      to_dump_q <= 1'b0;
      last_q <= lg_src_lp'(num_src_p - 1);
      s1_v_q <= 1'b0;
      s1_addr_q <= '0;
      byp_v_q <= 1'b0;
      byp_addr_q <= '0;
      byp_data_q <= '0;
      overflow_q <= 1'b0;
      rd_idx_q <= '0;
      fetched_q <= 1'b0;
      fetch_addr_q <= '0;
      dump_v_q <= 1'b0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
      busy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      clr_addr_q <= clr_addr_d;
      to_dump_q <= to_dump_d;
      last_q <= last_d;
      s1_v_q <= s1_v_d;
      s1_addr_q <= s1_addr_d;
      byp_v_q <= byp_v_d;
      byp_addr_q <= byp_addr_d;
      byp_data_q <= byp_data_d;
      overflow_q <= overflow_d;
      rd_idx_q <= rd_idx_d;
      fetched_q <= fetched_d;
      fetch_addr_q <= fetch_addr_d;
      dump_v_q <= dump_v_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
      busy_q <= busy_d;
    end
  end
  assign req_yumi_o = yumi;
  assign dump_v_o = dump_v_q;
  assign dump_addr_o = dump_addr_q;
  assign dump_data_o = dump_data_q;
  assign busy_o = busy_q;
  assign overflow_o = overflow_q;
endmodule

// File: tb/tb_vanilla_pc_hist_counter_ctrl.sv
// tb_vanilla_pc_hist_counter_ctrl: directed stimulus with queue scoreboard for grants and dump entries
module tb_vanilla_pc_hist_counter_ctrl;
  localparam int ns = 4;
  localparam int els = 256;
  localparam int cw = 4;
  localparam int lg = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  logic dump = 1'b0;
  logic dump_ready = 1'b1;
  logic [ns-1:0] req_v = '0;
  logic [ns*lg-1:0] req_addr = '0;
  logic [ns-1:0] req_yumi;
  logic dump_v, busy, overflow;
  logic [lg-1:0] dump_addr;
  logic [cw-1:0] dump_data;
  int checks = 0;
  int errors = 0;
  int exp_gnt[$];
  int exp_daddr[$];
  int exp_ddata[$];
  int tbl[els];
  int prev_v = 0, prev_rdy = 0, prev_addr = 0, prev_data = 0, g, n;
  vanilla_pc_hist_counter_ctrl #(.num_src_p(ns), .els_p(els), .ctr_width_p(cw)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clear), .dump_i(dump),
    .req_v_i(req_v), .req_addr_i(req_addr), .req_yumi_o(req_yumi),
    .dump_v_o(dump_v), .dump_addr_o(dump_addr), .dump_data_o(dump_data),
    .dump_ready_i(dump_ready), .busy_o(busy), .overflow_o(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_chk();
    chk("rst_yumi", int'(req_yumi), 0);
    chk("rst_dump_v", int'(dump_v), 0);
    chk("rst_dump_addr", int'(dump_addr), 0);
    chk("rst_dump_data", int'(dump_data), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_busy", int'(busy), 1);
  endtask
  task automatic wait_idle(input string name);
    for (int k = 0; k < 2000 && busy; k++) tick();
    chk(name, int'(busy), 0);
  endtask
  task automatic incr(input int src, input int addr, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      req_v = ns'(1 << src);
      req_addr[src*lg +: lg] = lg'(addr);
      exp_gnt.push_back(src);
      tick();
    end
    req_v = '0;
    repeat (3) tick();
    chk("grant_left", exp_gnt.size(), 0);
  endtask
  task automatic do_dump(input bit toggle);
    for (int a = 0; a < els; a++) begin
      exp_daddr.push_back(a);
      exp_ddata.push_back(tbl[a]);
    end
    dump = 1'b1;
    dump_ready = 1'b1;
    tick();
    dump = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      dump_ready = toggle ? (k % 2 == 0) : 1'b1;
      tick();
      if (!busy) break;
    end
    dump_ready = 1'b1;
    chk("dump_done", int'(busy), 0);
    chk("dump_left", exp_daddr.size(), 0);
  endtask
  always @(negedge clk) begin
    if (!rst_n) prev_v = 0;
    else begin
      if (prev_v != 0 && prev_rdy == 0) begin
        chk("stall_v", int'(dump_v), 1);
        chk("stall_addr", int'(dump_addr), prev_addr);
        chk("stall_data", int'(dump_data), prev_data);
      end
      if (req_yumi != '0) begin
        if (exp_gnt.size() == 0) chk("spurious_grant", int'(req_yumi), 0);
        else begin
          g = exp_gnt.pop_front();
          chk("grant", int'(req_yumi), 1 << g);
        end
      end
      if (dump_v && dump_ready) begin
        if (exp_daddr.size() == 0) chk("spurious_dump", int'(dump_v), 0);
        else begin
          chk("dump_addr", int'(dump_addr), exp_daddr.pop_front());
          chk("dump_data", int'(dump_data), exp_ddata.pop_front());
        end
      end
      prev_v = int'(dump_v);
      prev_rdy = int'(dump_ready);
      prev_addr = int'(dump_addr);
      prev_data = int'(dump_data);
    end
  end
  initial begin
    foreach (tbl[a]) tbl[a] = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_chk();
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("busy_cycles", n, 256);
    do_dump(1'b0);
    for (int k = 0; k < 8; k++) begin
      req_v = '1;
      req_addr = {8'd4, 8'd3, 8'd2, 8'd1};
      exp_gnt.push_back(k % 4);
      tick();
    end
    req_v = '0;
    repeat (3) tick();
    chk("grant_left", exp_gnt.size(), 0);
    for (int a = 1; a <= 4; a++) tbl[a] = 2;
    incr(2, 5, 10);
    tbl[5] = 10;
    chk("overflow_pre", int'(overflow), 0);
    do_dump(1'b1);
    incr(0, 7, 17);
    tbl[7] = 15;
    chk("overflow_set", int'(overflow), 1);
    do_dump(1'b0);
    clear = 1'b1;
    dump = 1'b1;
    tick();
    clear = 1'b0;
    dump = 1'b0;
    chk("clear_busy", int'(busy), 1);
    wait_idle("clear_idle");
    chk("overflow_clr", int'(overflow), 0);
    repeat (10) tick();
    foreach (tbl[a]) tbl[a] = 0;
    do_dump(1'b0);
    incr(1, 3, 3);
    tbl[3] = 3;
    for (int a = 0; a < els; a++) begin
      exp_daddr.push_back(a);
      exp_ddata.push_back(tbl[a]);
    end
    dump = 1'b1;
    tick();
    dump = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (dump_v && dump_addr == 8'd100) break;
    end
    chk("reach_100", int'(dump_addr), 100);
    #2 rst_n = 1'b0;
    #1 reset_chk();
    exp_daddr.delete();
    exp_ddata.delete();
    foreach (tbl[a]) tbl[a] = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle("sweep_idle");
    do_dump(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
